// File: rtl/ps2_pkg.sv
// Shared types and parity-mode constants for the PS/2 receive front end.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } ps2_rx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // ones_odd: XOR of data bits and the received parity bit.
   function automatic logic par_ok(input logic ones_odd, input int mode);
      if (mode == PAR_ODD)  return ones_odd;
      if (mode == PAR_EVEN) return ~ones_odd;
      return 1'b1;
   endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Small power-of-2 FIFO with a registered head word; a push while full is
// accepted only when a pop happens in the same cycle.
module ps2_rx_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   output logic [W-1:0]             head_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [W-1:0]  head_q, head_d;
   logic          wr_en, rd_en;

   assign full     = (count_q == (AW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign rd_en    = pop && !empty;
   assign wr_en    = push && (!full || rd_en);
   assign head_dat = head_q;
   assign count    = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // Bypass the incoming word when it lands in the slot that becomes head.
      if ((wr_en || rd_en) && count_d != '0) begin
         if (wr_en && wr_ptr_q == rd_ptr_d) head_d = push_dat;
         else                               head_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 receiver in the system clock domain: synchronise, filter, deframe, buffer.
// Define PS2_RX_TIMEOUT_EN to abandon frames whose clock stops mid-frame.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int PARITY      = 1,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4,
   parameter int TIMEOUT_CYC = 5000
) (
   input  logic                     Clk,
   input  logic                     nReset,
   input  logic                     ps2_nclk,
   input  logic                     ndata,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     parity_err,
   output logic                     frame_err,
   output logic                     overflow
);

   localparam int FCW = $clog2(FILT_LEN + 1);
   localparam int BCW = $clog2(DATA_W) + 1;

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
   logic                   filt_q, filt_d, strobe_q, strobe_d;
   logic [FCW-1:0]         fcnt_q, fcnt_d;
   ps2_rx_state_t          state_q, state_d;
   logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]      shift_q, shift_d, shift_in;
   logic [DATA_W:0]        shift_cat;
   logic                   par_ok_q, par_ok_d;
   logic                   push_q, push_d, perr_q, perr_d, ferr_q, ferr_d;
   logic                   clk_s, line, fifo_full, fifo_empty;

   // The data pin is inverted; synchronise the true line level.
   assign clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_nclk};
   assign dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ~ndata};
   assign clk_s      = clk_sync_q[SYNC_STAGES-1];
   assign line       = dat_sync_q[SYNC_STAGES-1];

   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      if (clk_s != filt_q) begin
         if (fcnt_q == FCW'(FILT_LEN)) filt_d = clk_s;
         else                          fcnt_d = fcnt_q + 1'b1;
      end
      strobe_d = filt_q & ~filt_d;
   end

   assign shift_cat = {line, shift_q};
   assign shift_in  = shift_cat[DATA_W:1];

`ifdef PS2_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_q, tmo_d;
`endif

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_ok_d  = par_ok_q;
      push_d    = 1'b0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
      if (strobe_q) begin
         case (state_q)
            ST_IDLE: begin
               if (!line) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
                  par_ok_d  = 1'b1;
               end
            end
            ST_DATA: begin
               shift_d = shift_in;
               if (bit_cnt_q == BCW'(DATA_W - 1))
                  state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
               else
                  bit_cnt_d = bit_cnt_q + 1'b1;
            end
            ST_PARITY: begin
               par_ok_d = par_ok(^shift_q ^ line, PARITY);
               state_d  = ST_STOP;
            end
            ST_STOP: begin
               if (!line)          ferr_d = 1'b1;
               else if (!par_ok_q) perr_d = 1'b1;
               else                push_d = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
`ifdef PS2_RX_TIMEOUT_EN
      tmo_d = '0;
      if (state_q != ST_IDLE && !strobe_q) begin
         if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = ST_IDLE;
            ferr_d  = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         filt_q     <= 1'b1;
         fcnt_q     <= '0;
         strobe_q   <= 1'b0;
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_ok_q   <= 1'b1;
         push_q     <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
         tmo_q      <= '0;
`endif
      end else begin
         clk_sync_q <= clk_sync_d;
         dat_sync_q <= dat_sync_d;
         filt_q     <= filt_d;
         fcnt_q     <= fcnt_d;
         strobe_q   <= strobe_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_ok_q   <= par_ok_d;
         push_q     <= push_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
`ifdef PS2_RX_TIMEOUT_EN
         tmo_q      <= tmo_d;
`endif
      end
   end

   ps2_rx_fifo #(
      .W     (DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (Clk),
      .rst_n    (nReset),
      .push     (push_q),
      .push_dat (shift_q),
      .pop      (rd_valid && rd_ready),
      .head_dat (rd_data),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   assign rd_valid   = ~fifo_empty;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign overflow   = push_q && fifo_full && !rd_ready;

endmodule
